// File: rtl/alu_frame_packer.sv
// alu_frame_packer
//   Tags a stream of ALU result bytes with a free-running 3-bit op index and a
//   one-op-delayed carry flag. It packs aligned 8-op frames into a
//   first-word-fall-through FIFO and discards whole-frame remainders on
//   overflow.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   enable     capture enable, honoured at frame start (tag 0) and frame end (tag 7)
//   in_valid   ALU result present this cycle
//   in_data    ALU result byte
//   in_carry   carry/borrow flag belonging to the previous op
//   out_ready  consumer accepts the head entry
//   out_valid  FIFO non-empty
//   out_data   head entry {carry, op[2:0], data[7:0]}, 0 when empty
//   out_last   head entry is op 7, 0 when empty
//   overflow   sticky sample-loss flag
//   drop_cnt   saturating count of discarded samples
//   frame_cnt  wrapping count of pushed op-7 entries
module alu_frame_packer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_carry,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [11:0] out_data,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned TW = 3;
  localparam int unsigned EW = 1 + TW + DW;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tag;
  logic            r_carry_d;
  logic [EW:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [7:0]      r_drop_cnt;
  logic [7:0]      r_frame_cnt;

  logic            w_full;
  logic            w_pop;
  logic            w_can_accept;
  logic            w_tag_first;
  logic            w_tag_last;
  logic            w_start;
  logic            w_push;
  logic            w_drop;
  logic [EW:0]     w_head;

  // FIFO status; a same-cycle pop frees a slot for the incoming sample
  assign out_valid    = (r_count != CW'(0));
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_pop        = out_valid & out_ready;
  assign w_can_accept = ~w_full | w_pop;

  assign w_tag_first  = (r_tag == TW'(0));
  assign w_tag_last   = (r_tag == TW'(7));
  // Frame start condition shared by IDLE and by DROP at tag 0
  assign w_start      = in_valid & enable & w_tag_first & w_can_accept;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (in_valid) begin
          if (!w_can_accept)            w_state_nxt = S_DROP;
          else if (w_tag_last && !enable) w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (in_valid && w_tag_first) w_state_nxt = w_start ? S_CAPTURE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Push/drop decode
  always_comb begin
    w_push = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_push = w_start;
      end
      S_CAPTURE: begin
        w_push = in_valid & w_can_accept;
        w_drop = in_valid & ~w_can_accept;
      end
      S_DROP: begin
        if (in_valid) begin
          if (w_tag_first) w_push = w_start;
          else             w_drop = 1'b1;
        end
      end
      default: begin
        w_push = 1'b0;
        w_drop = 1'b0;
      end
    endcase
  end

  // Op tag and delayed carry follow every valid sample regardless of state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag     <= '0;
      r_carry_d <= 1'b0;
    end else if (in_valid) begin
      r_tag     <= r_tag + TW'(1);
      r_carry_d <= in_carry;
    end
  end

  // Entry storage; contents are don't-care while not counted
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_tag_last, r_carry_d, r_tag, in_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Loss and frame statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_push && w_tag_last) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Head entry, forced to zero while empty
  assign w_head    = r_mem[r_rd_ptr];
  assign out_data  = out_valid ? w_head[EW-1:0] : '0;
  assign out_last  = out_valid ? w_head[EW] : 1'b0;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_alu_frame_packer.sv
// tb_alu_frame_packer
//   Directed bench for alu_frame_packer: frame capture, carry alignment,
//   enable handling, overflow/drop path, full-FIFO push+pop and async reset.
module tb_alu_frame_packer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_carry;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  alu_frame_packer #(.DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_carry  (in_carry),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    in_carry = c;
    step();
    in_valid = 1'b0;
    in_carry = 1'b0;
  endtask

  task automatic pop(input string nm, input logic [11:0] ed, input logic el);
    check({nm, "_valid"}, 16'(out_valid), 16'd1);
    check({nm, "_data"},  16'(out_data),  16'(ed));
    check({nm, "_last"},  16'(out_last),  16'(el));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_empty(input string nm);
    check({nm, "_valid"}, 16'(out_valid), 16'd0);
    check({nm, "_data"},  16'(out_data),  16'd0);
    check({nm, "_last"},  16'(out_last),  16'd0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_empty("rst");
    check("rst_ovf",   16'(overflow),  16'd0);
    check("rst_drop",  16'(drop_cnt),  16'd0);
    check("rst_frame", 16'(frame_cnt), 16'd0);

    // Basic frame: carry lags by one op, out_last only on op 7
    enable = 1'b1;
    send(8'h10, 1'b1);
    check("lat_valid", 16'(out_valid), 16'd1);
    check("lat_data",  16'(out_data),  16'h010);
    for (int k = 1; k < 8; k++) send(8'(8'h10 + k), 1'b0);
    check("f1_frame", 16'(frame_cnt), 16'd1);
    pop("f1_e0", 12'h010, 1'b0);
    pop("f1_e1", 12'h911, 1'b0);
    for (int k = 2; k < 8; k++)
      pop($sformatf("f1_e%0d", k), 12'((k << 8) | (8'h10 + k)), (k == 7));
    check_empty("f1_end");

    // enable drops at op 4: frame completes, later frames ignored
    for (int k = 0; k < 4; k++) send(8'(8'h40 + k), 1'b0);
    enable = 1'b0;
    for (int k = 4; k < 8; k++) send(8'(8'h40 + k), 1'b0);
    for (int k = 0; k < 8; k++) send(8'(8'h50 + k), 1'b0);
    check("f2_frame", 16'(frame_cnt), 16'd2);
    for (int k = 0; k < 8; k++)
      pop($sformatf("f2_e%0d", k), 12'((k << 8) | (8'h40 + k)), (k == 7));
    check_empty("f2_end");

    // Async reset mid-frame with entries buffered
    enable = 1'b1;
    for (int k = 0; k < 5; k++) send(8'(8'h60 + k), 1'b0);
    enable = 1'b0;
    check("pre_rst_valid", 16'(out_valid), 16'd1);
    #2 reset = 1'b1;
    #1;
    check_empty("mid_rst");
    check("mid_rst_frame", 16'(frame_cnt), 16'd0);
    check("mid_rst_drop",  16'(drop_cnt),  16'd0);
    check("mid_rst_ovf",   16'(overflow),  16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Tag restarts at 0; enable raised at op 3 waits for the next op 0
    for (int k = 0; k < 3; k++) send(8'(8'h70 + k), 1'b0);
    enable = 1'b1;
    for (int k = 3; k < 8; k++) send(8'(8'h70 + k), 1'b0);
    check("late_en_valid", 16'(out_valid), 16'd0);
    send(8'hA0, 1'b0);
    check("late_en_first", 16'(out_data), 16'h0A0);
    enable = 1'b0;
    for (int k = 1; k < 8; k++) send(8'(8'hA0 + k), 1'b0);
    for (int k = 0; k < 8; k++)
      pop($sformatf("f3_e%0d", k), 12'((k << 8) | (8'hA0 + k)), (k == 7));
    check_empty("f3_end");
    check("f3_frame", 16'(frame_cnt), 16'd1);

    // Fill to full, then push+pop at full, then overflow into DROP
    reset = 1'b1;
    step();
    reset = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 16; k++) send(8'(8'h20 + k), 1'b0);
    check("full_ovf",   16'(overflow),  16'd0);
    check("full_frame", 16'(frame_cnt), 16'd2);
    check("full_head",  16'(out_data),  16'h020);
    out_ready = 1'b1;
    send(8'h77, 1'b0);
    out_ready = 1'b0;
    check("pp_head", 16'(out_data), 16'h121);
    check("pp_ovf",  16'(overflow), 16'd0);
    check("pp_drop", 16'(drop_cnt), 16'd0);
    send(8'h78, 1'b0);
    check("ovf_set",  16'(overflow), 16'd1);
    check("ovf_drop", 16'(drop_cnt), 16'd1);
    for (int k = 2; k < 8; k++) send(8'(8'h78 + k), 1'b0);
    check("drop_cnt7",  16'(drop_cnt),  16'd7);
    check("drop_frame", 16'(frame_cnt), 16'd2);
    for (int k = 1; k < 16; k++)
      pop($sformatf("ff_e%0d", k), 12'(((k % 8) << 8) | (8'h20 + k)), ((k % 8) == 7));
    pop("ff_pp", 12'h077, 1'b0);
    check_empty("ff_end");

    // Recovery from DROP at next op 0
    send(8'h30, 1'b0);
    enable = 1'b0;
    for (int k = 1; k < 8; k++) send(8'(8'h30 + k), 1'b0);
    check("rec_frame", 16'(frame_cnt), 16'd3);
    check("rec_ovf",   16'(overflow),  16'd1);
    check("rec_drop",  16'(drop_cnt),  16'd7);
    for (int k = 0; k < 8; k++)
      pop($sformatf("rec_e%0d", k), 12'((k << 8) | (8'h30 + k)), (k == 7));
    check_empty("rec_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
